// File: rtl/regfile_sb.sv
// regfile_sb: 2-read/2-write register file with write-first bypass,
// port-1 write priority, optional hard-wired zero register and busy scoreboard.
module regfile_sb #(
    parameter int DATA_W   = 64,
    parameter int ADDR_W   = 5,
    parameter bit ZERO_REG = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    rd_en0,
    input  logic                    rd_en1,
    input  logic [ADDR_W-1:0]       rd_addr0,
    input  logic [ADDR_W-1:0]       rd_addr1,
    output logic [DATA_W-1:0]       rd_data0,
    output logic [DATA_W-1:0]       rd_data1,
    output logic                    rd_busy0,
    output logic                    rd_busy1,
    input  logic                    wr_en0,
    input  logic                    wr_en1,
    input  logic [ADDR_W-1:0]       wr_addr0,
    input  logic [ADDR_W-1:0]       wr_addr1,
    input  logic [DATA_W-1:0]       wr_data0,
    input  logic [DATA_W-1:0]       wr_data1,
    input  logic                    rsv_en,
    input  logic [ADDR_W-1:0]       rsv_addr,
    output logic [(2**ADDR_W)-1:0]  busy_vec
);
    localparam int DEPTH = 2 ** ADDR_W;
    logic [DEPTH-1:0][DATA_W-1:0] mem, mem_d;
    logic [DEPTH-1:0]             busy_q, busy_d;
    // Next state doubles as the read source, giving write-first bypass for free
    always_comb begin
        mem_d  = mem;
        busy_d = busy_q;
        if (wr_en0) begin
            mem_d[wr_addr0]  = wr_data0;
            busy_d[wr_addr0] = 1'b0;
        end
        if (wr_en1) begin
            mem_d[wr_addr1]  = wr_data1;
            busy_d[wr_addr1] = 1'b0;
        end
        if (rsv_en)
            busy_d[rsv_addr] = 1'b1;
        if (ZERO_REG) begin
            mem_d[0]  = '0;
            busy_d[0] = 1'b0;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem      <= '0;
            busy_q   <= '0;
            rd_data0 <= '0;
            rd_data1 <= '0;
            rd_busy0 <= 1'b0;
            rd_busy1 <= 1'b0;
        end else begin
            mem    <= mem_d;
            busy_q <= busy_d;
            if (rd_en0) begin
                rd_data0 <= mem_d[rd_addr0];
                rd_busy0 <= busy_d[rd_addr0];
            end
            if (rd_en1) begin
                rd_data1 <= mem_d[rd_addr1];
                rd_busy1 <= busy_d[rd_addr1];
            end
        end
    end
    assign busy_vec = busy_q;
endmodule
